// File: rtl/conv_fir.sv
// Sequential multiply-accumulate FIR filter: one tap per cycle over a TAPS-deep delay line,
// with runtime-writable signed coefficients and a valid/ready result handshake.
module conv_fir #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 8,
   localparam int IDX_W = $clog2(TAPS),
   localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   input  logic                     coef_we,
   input  logic [IDX_W-1:0]         coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     flush,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  out_data,
   input  logic                     out_ready
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                    state_r;
   logic signed [DATA_W-1:0]  x_r [TAPS];
   logic signed [COEF_W-1:0]  c_r [TAPS];
   logic signed [ACC_W-1:0]   acc_r;
   logic [IDX_W-1:0]          idx_r;

   logic signed [PROD_W-1:0]  x_ext_s;
   logic signed [PROD_W-1:0]  c_ext_s;
   logic signed [PROD_W-1:0]  prod_s;
   logic signed [ACC_W-1:0]   sum_s;
   logic                      coef_wr_s;

   assign in_ready = (state_r == IDLE);

   // Current tap product, sign-extended into the accumulator so the running sum never wraps.
   always_comb begin
      x_ext_s = {{COEF_W{x_r[idx_r][DATA_W-1]}}, x_r[idx_r]};
      c_ext_s = {{DATA_W{c_r[idx_r][COEF_W-1]}}, c_r[idx_r]};
      prod_s  = x_ext_s * c_ext_s;
      sum_s   = acc_r + {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};
   end

   // Coefficients are writable only while idle and only at an in-range index.
   always_comb begin
      coef_wr_s = 1'b0;
      if (coef_we && (state_r == IDLE) && (int'(coef_addr) < TAPS)) begin
         coef_wr_s = 1'b1;
      end else begin
         coef_wr_s = 1'b0;
      end
   end

   // Control FSM, delay line, coefficient bank, accumulator and registered result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         acc_r     <= {ACC_W{1'b0}};
         idx_r     <= {IDX_W{1'b0}};
         out_valid <= 1'b0;
         out_data  <= {ACC_W{1'b0}};
         for (int k = 0; k < TAPS; k++) begin
            x_r[k] <= {DATA_W{1'b0}};
            c_r[k] <= {COEF_W{1'b0}};
         end
      end else begin
         if (coef_wr_s) begin
            c_r[coef_addr] <= coef_data;
         end
         // flush outranks any accept or handshake in the same cycle; coefficients survive it.
         if (flush) begin
            state_r   <= IDLE;
            acc_r     <= {ACC_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {ACC_W{1'b0}};
            for (int k = 0; k < TAPS; k++) begin
               x_r[k] <= {DATA_W{1'b0}};
            end
         end else begin
            case (state_r)
               IDLE: begin
                  if (in_valid) begin
                     x_r[0] <= in_data;
                     for (int k = 1; k < TAPS; k++) begin
                        x_r[k] <= x_r[k-1];
                     end
                     acc_r   <= {ACC_W{1'b0}};
                     idx_r   <= {IDX_W{1'b0}};
                     state_r <= MAC;
                  end
               end
               MAC: begin
                  acc_r <= sum_s;
                  if (idx_r == LAST_IDX) begin
                     idx_r     <= {IDX_W{1'b0}};
                     out_valid <= 1'b1;
                     out_data  <= sum_s;
                     state_r   <= OUT;
                  end else begin
                     idx_r <= idx_r + IDX_ONE;
                  end
               end
               OUT: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     out_data  <= {ACC_W{1'b0}};
                     state_r   <= IDLE;
                  end
               end
               default: begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  out_data  <= {ACC_W{1'b0}};
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_fir.sv
// Directed self-checking bench for conv_fir at default parameters (8 taps, 8-bit data/coefs).
module tb_conv_fir;

   logic               clk;
   logic               reset;
   logic               in_valid;
   logic signed [7:0]  in_data;
   logic               in_ready;
   logic               coef_we;
   logic [2:0]         coef_addr;
   logic signed [7:0]  coef_data;
   logic               flush;
   logic               out_valid;
   logic signed [18:0] out_data;
   logic               out_ready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   conv_fir dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 40 && !in_ready; i++) tick();
      if (!in_ready) check("ready_timeout", in_ready, 1);
   endtask

   task automatic wait_out(output logic signed [18:0] y);
      for (int i = 0; i < 40 && !out_valid; i++) tick();
      if (!out_valid) check("out_timeout", out_valid, 1);
      y = out_data;
      if (out_ready) tick();
   endtask

   // Accepts one sample; returns the result and accept edge -> out_valid latency.
   task automatic run(input int d, output logic signed [18:0] y, output int lat,
                      output int acc_cyc);
      wait_ready();
      in_valid = 1'b1;
      in_data  = d[7:0];
      tick();
      in_valid = 1'b0;
      acc_cyc  = cyc;
      for (int i = 0; i < 40 && !out_valid; i++) tick();
      lat = cyc - acc_cyc;
      wait_out(y);
   endtask

   task automatic set_coef(input int a, input int v);
      coef_we   = 1'b1;
      coef_addr = a[2:0];
      coef_data = v[7:0];
      tick();
      coef_we   = 1'b0;
   endtask

   initial begin
      logic signed [18:0] y;
      int lat, a0, a1, seen;
      reset = 1'b1; in_valid = 1'b0; in_data = 8'sd0; coef_we = 1'b0;
      coef_addr = 3'd0; coef_data = 8'sd0; flush = 1'b0; out_ready = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      tick(); tick();
      reset = 1'b0;

      // Impulse response with c[k]=k+1
      for (int k = 0; k < 8; k++) set_coef(k, k + 1);
      run(1, y, lat, a0);
      check("impulse_0", y, 1);
      check("latency", lat, 8);
      for (int k = 1; k < 8; k++) begin
         run(0, y, lat, a1);
         check($sformatf("impulse_%0d", k), y, k + 1);
         if (k == 1) check("sample_period", a1 - a0, 10);
      end

      // Backpressure: x=[3,0..] -> 3
      out_ready = 1'b0;
      run(3, y, lat, a0);
      check("bp_value", y, 3);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_data", out_data, 3);
         check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", out_valid, 0);
      check("bp_release_data", out_data, 0);
      check("bp_release_ready", in_ready, 1);
      tick();
      check("bp_single_result", out_valid, 0);

      flush = 1'b1; tick(); flush = 1'b0;

      // Coefficient write during MAC is ignored
      wait_ready();
      in_valid = 1'b1; in_data = 8'sd1; tick(); in_valid = 1'b0;
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'sd5; tick(); coef_we = 1'b0;
      wait_out(y);
      check("mac_write_cur", y, 1);
      run(1, y, lat, a0);
      check("mac_write_next", y, 3);
      set_coef(0, 5);
      run(2, y, lat, a0);
      check("idle_write_used", y, 15);

      // Write and accept in the same IDLE cycle: x=[1,2,1,1,0..], c0=7 -> 18
      wait_ready();
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'sd7;
      in_valid = 1'b1; in_data = 8'sd1;
      tick();
      coef_we = 1'b0; in_valid = 1'b0;
      wait_out(y);
      check("write_and_accept", y, 18);

      // Flush removes history but keeps coefficients
      run(5, y, lat, a0); run(6, y, lat, a0); run(7, y, lat, a0);
      flush = 1'b1; tick(); flush = 1'b0;
      run(1, y, lat, a0);
      check("flush_impulse_0", y, 7);
      run(0, y, lat, a0);
      check("flush_impulse_1", y, 2);

      // flush beats a simultaneous sample
      wait_ready();
      flush = 1'b1; in_valid = 1'b1; in_data = 8'sd9;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_drop_ready", in_ready, 1);
      run(1, y, lat, a0);
      check("flush_drop_value", y, 7);

      // flush discards a pending result: x=[4,1,0..] -> 28+2
      out_ready = 1'b0;
      run(4, y, lat, a0);
      check("pending_value", y, 30);
      flush = 1'b1; tick(); flush = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_out_data", out_data, 0);
      check("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      tick();
      check("flush_no_result", out_valid, 0);

      // Extremes
      for (int k = 0; k < 8; k++) set_coef(k, -128);
      for (int k = 0; k < 8; k++) run(-128, y, lat, a0);
      check("extreme_pos", y, 131072);
      for (int k = 0; k < 8; k++) set_coef(k, 127);
      run(-128, y, lat, a0);
      check("extreme_neg", y, -130048);

      // Async reset while a result is held: x=[1,-128 x7] -> 127 - 7*16256
      out_ready = 1'b0;
      run(1, y, lat, a0);
      check("held_value", y, -113665);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_data", out_data, 0);
      check("async_rst_ready", in_ready, 1);
      tick(); tick();
      reset = 1'b0;
      out_ready = 1'b1;

      // Async reset mid-MAC aborts with no output
      wait_ready();
      in_valid = 1'b1; in_data = 8'sd5; tick(); in_valid = 1'b0;
      tick(); tick();
      check("in_mac_ready", in_ready, 0);
      #2 reset = 1'b1;
      #1;
      check("mac_rst_valid", out_valid, 0);
      check("mac_rst_data", out_data, 0);
      check("mac_rst_ready", in_ready, 1);
      tick();
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("mac_rst_no_output", seen, 0);
      run(1, y, lat, a0);
      check("cleared_coef_0", y, 0);
      run(0, y, lat, a0);
      check("cleared_coef_1", y, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_fir.md
CONV_FIR -- requirements
Module: conv_fir

Interface
REQ-001 Parameter DATA_W, default 8: width of signed input samples.
REQ-002 Parameter COEF_W, default 8: width of signed coefficients.
REQ-003 Parameter TAPS, default 8, range 2..64: number of filter taps (delay-line depth).
REQ-004 Derived ACC_W = DATA_W + COEF_W + clog2(TAPS) (19 at defaults): accumulator and output width.
REQ-005 One clock; reset is asynchronous and active-high: ports clk and reset.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 in_valid  in  1  input sample present.
REQ-009 in_data  in  DATA_W  signed input sample.
REQ-010 in_ready  out  1  block accepts a sample this cycle.
REQ-011 coef_we  in  1  coefficient write strobe.
REQ-012 coef_addr  in  clog2(TAPS)  coefficient index.
REQ-013 coef_data  in  COEF_W  signed coefficient value.
REQ-014 flush  in  1  synchronous clear of delay line and abort of current operation.
REQ-015 out_valid  out  1  result present.
REQ-016 out_data  out  ACC_W  signed result y[n] = sum over k of c[k]*x[n-k].
REQ-017 out_ready  in  1  downstream accepts result.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, MAC, OUT; in_ready SHALL equal (state==IDLE), combinational.
REQ-019 IDLE: on in_valid&&in_ready the block SHALL shift the delay line (x[0]<=in_data, x[k]<=x[k-1]), clear acc and tap index, and go to MAC.
REQ-020 MAC: each cycle acc <= acc + x[idx]*c[idx], full-precision signed, idx incremented; after the idx==TAPS-1 term the FSM SHALL go to OUT.
REQ-021 out_valid SHALL rise on the TAPS-th rising edge after the accepting edge, with out_data = final acc.
REQ-022 OUT: out_valid=1 and out_data SHALL hold stable until out_valid&&out_ready; on that edge the FSM SHALL go to IDLE and out_valid SHALL drop.
REQ-023 out_data SHALL read 0 whenever out_valid=0.
REQ-024 Minimum sample period with out_ready tied high SHALL be TAPS+2 cycles.
REQ-025 Coefficient writes SHALL take effect only in IDLE; writes in MAC or OUT, or with coef_addr >= TAPS, SHALL be ignored.
REQ-026 A coefficient write and a sample accept in the same IDLE cycle SHALL both occur; the following MAC SHALL use the new coefficient.
REQ-027 flush SHALL, on the next edge, zero the delay line and acc, drop out_valid, discard any pending result, and return to IDLE; coefficients SHALL be kept.
REQ-028 flush and in_valid in the same IDLE cycle: flush SHALL win and the sample SHALL be dropped.
REQ-029 No overflow SHALL be possible: ACC_W covers TAPS*(-2^(DATA_W-1))*(-2^(COEF_W-1)).

Reset
REQ-030 reset SHALL immediately, regardless of clk: state=IDLE, delay line=0, all coefficients=0, acc=0, idx=0, out_valid=0, out_data=0.
REQ-031 While reset is high, in_valid and coef_we SHALL be ignored; an operation in progress SHALL be aborted with no output.
REQ-032 The first sample SHALL be accepted no earlier than the first rising edge after reset deasserts.

Verification
REQ-033 Impulse: coefs c[k]=k+1, feed 1 then seven 0s, out_ready=1 -> out_data sequence 1,2,3,4,5,6,7,8.
REQ-034 Extremes: all coefs -128, eight samples of -128 -> 8th out_data = 131072, no wrap; all coefs 127 with samples -128 -> 8th out_data = -130048.
REQ-035 Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid=1 and out_data constant, in_ready=0 throughout; single result on release.
REQ-036 Coef write during MAC (addr 0, value 5, prior 1) -> current result uses 1; next sample uses 5 only if rewritten in IDLE.
REQ-037 Reset asserted mid-MAC -> out_valid=0 and out_data=0 immediately; after release an impulse yields all-zero outputs (coefs cleared).
REQ-038 flush after 3 nonzero samples -> next impulse response equals coefs only, no history contribution.
